// File: rtl/serial_shifter_pkg.sv
// Shared definitions for the serial shifter: opcodes, FSM encoding and size defaults.
package serial_shifter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational opcode decode; at most one enable is high.
module shift_op_decode
    import serial_shifter_pkg::*;
(
    input  logic [4:0] ctrl_ALUopcode,
    output logic       sll_en,
    output logic       sra_en
);

    always_comb begin
        sll_en = (ctrl_ALUopcode == OP_SLL);
        sra_en = (ctrl_ALUopcode == OP_SRA);
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: one bit per clock, SLL (zero fill) or SRA (sign fill).
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic             start,
    output logic [WIDTH-1:0] data_result,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             op_sra;
    logic             sll_en;
    logic             sra_en;
    logic             accept;

    shift_op_decode u_decode (
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .sll_en         (sll_en),
        .sra_en         (sra_en)
    );

    always_comb begin
        accept    = start && (state == IDLE || state == DONE) && (sll_en || sra_en);
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = (ctrl_shiftamt == '0) ? DONE : SHIFT;
                else
                    state_nxt = IDLE;
            end
            SHIFT: begin
                if (cnt == SHW'(1))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_sra <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc    <= data_operandA;
                cnt    <= ctrl_shiftamt;
                op_sra <= sra_en;
            end else if (state == SHIFT) begin
                acc <= op_sra ? {acc[WIDTH-1], acc[WIDTH-1:1]} : {acc[WIDTH-2:0], 1'b0};
                cnt <= cnt - SHW'(1);
            end
        end
    end

    always_comb begin
        data_result = acc;
        busy        = (state == SHIFT);
        done        = (state == DONE);
    end

endmodule

// File: tb/tb_serial_shifter.sv
// Randomized scoreboard bench for serial_shifter against a shift-operator reference model.
module tb_serial_shifter;
    import serial_shifter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ctrl_ALUopcode = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic [31:0] data_operandA = '0;
    logic        start = 1'b0;
    logic [31:0] data_result;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          ready_cyc = 0;
    logic [31:0] hold = '0;
    int          checks = 0;
    int          errors = 0;

    serial_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .start          (start),
        .data_result    (data_result),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input int s);
        logic signed [31:0] sa;
        sa = $signed(a);
        if (op == OP_SLL)
            return a << s;
        return $unsigned(sa >>> s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [4:0] s);
        exp_t e;
        @(negedge clock);
        start          = 1'b1;
        ctrl_ALUopcode = op;
        data_operandA  = a;
        ctrl_shiftamt  = s;
        // Accepted only when nothing is in flight, or in the done cycle itself.
        if ((op == OP_SLL || op == OP_SRA) && cyc >= ready_cyc) begin
            e.res = model(op, a, int'(s));
            e.cyc = cyc + int'(s) + 1;
            q.push_back(e);
            acc_cyc   = cyc;
            ready_cyc = e.cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        start     = 1'b0;
        q.delete();
        hold      = '0;
        acc_cyc   = 0;
        ready_cyc = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic exp_done;
        logic exp_busy;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                check("reset_result", data_result, 32'd0);
            end else begin
                exp_done = (q.size() > 0) && (q[0].cyc == cyc);
                exp_busy = (cyc > acc_cyc) && (cyc < ready_cyc);
                check("busy", 32'(busy), 32'(exp_busy));
                check("done", 32'(done), 32'(exp_done));
                if (exp_done) begin
                    check("result", data_result, q[0].res);
                    hold = q[0].res;
                    void'(q.pop_front());
                end else if (q.size() == 0) begin
                    check("hold", data_result, hold);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  op;
        logic [4:0]  s;
        int          mode;
        repeat (2) @(negedge clock);
        do_reset();

        issue(OP_SLL, 32'h0000_0001, 5'd4);
        idle(8);
        issue(OP_SRA, 32'h8000_0000, 5'd31);
        idle(34);
        issue(OP_SRA, 32'h4000_0000, 5'd30);
        idle(33);
        issue(OP_SLL, 32'hDEAD_BEEF, 5'd0);
        idle(3);
        issue(5'b00000, 32'h1234_5678, 5'd3);
        idle(10);

        issue(OP_SLL, 32'h0000_00A5, 5'd8);
        idle(2);
        do_reset();
        idle(12);

        issue(OP_SLL, 32'h0000_0003, 5'd5);
        repeat (5) issue(OP_SRA, $urandom, 5'($urandom));
        issue(OP_SRA, 32'hFFFF_FF00, 5'd4);
        idle(8);

        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                op = 5'($urandom);
                if (op == OP_SLL || op == OP_SRA)
                    op = op ^ 5'b10000;
            end else begin
                op = (mode < 5) ? OP_SLL : OP_SRA;
            end
            s = 5'($urandom);
            issue(op, $urandom, s);
            mode = $urandom_range(0, 15);
            if (mode == 0) begin
                idle(int'(s) / 2);
                do_reset();
            end else if (mode < 5) begin
                idle(int'(s));
            end else if (mode < 9) begin
                repeat (int'(s)) issue(($urandom_range(0, 1) != 0) ? OP_SLL : OP_SRA, $urandom, 5'($urandom));
            end else begin
                idle(int'(s) + $urandom_range(1, 4));
            end
        end

        idle(40);
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
